store_monitor: RTL and testbench
================================

// Module: store_monitor
// PURPOSE
//  Synthesizable self-check unit sitting directly downstream of the MIPS top's data-memory write port.
//  Consumes (memwrite, dataadr, writedata) every cycle.
//  Decides pass/fail against a success signature, detects timeout, and logs recent stores in a trace buffer.
//  The trace buffer is drained over a valid/request readout port.
// PARAMETERS
//  PASS_ADDR    32'd84          store address of the success signature
//  PASS_DATA    32'h00001118    store data of the success signature
//  ALLOW_ADDR0  32'd80          address of a permitted intermediate store
//  ALLOW_ADDR1  32'h00001107    address of a permitted intermediate store
//  DEPTH        8               trace buffer entries (power of 2, >=2)
//  TIMEOUT      1000            cycles in RUN with no verdict before timeout fail
// PORTS
//  clk          in   1    rising-edge clock
//  reset        in   1    synchronous, active-high reset
//  memwrite     in   1    store strobe from top
//  dataadr      in   32   store address from top
//  writedata    in   32   store data from top
//  rd_req       in   1    pop request for the oldest trace entry
//  rd_valid     out  1    rd_addr/rd_data valid this cycle (1-cycle pulse)
//  rd_addr      out  32   popped store address
//  rd_data      out  32   popped store data
//  trace_count  out  $clog2(DEPTH)+1   entries currently held
//  overflow     out  1    sticky: an entry was dropped due to full buffer
//  done         out  1    verdict reached (pass|fail)
//  pass         out  1    success signature seen
//  fail         out  1    bad store or timeout
//  fail_code    out  2    0 none, 1 illegal store, 2 timeout
//  store_count  out  16   stores accepted in RUN; saturates at 16'hFFFF
// BEHAVIOUR
//  - All state registered on posedge clk. Reset (sync, high) takes priority over everything:
//    FSM=RUN, FIFO emptied, cycle counter=0; all outputs 0 incl. rd_addr/rd_data; overflow cleared.
//    Applies identically mid-operation and after a verdict.
//  - FSM states: RUN -> PASS | FAIL. PASS and FAIL hold until reset.
//  - RUN store evaluation (memwrite=1), in priority order:
//    - dataadr==PASS_ADDR && writedata==PASS_DATA -> PASS.
//    - dataadr==ALLOW_ADDR0 or ALLOW_ADDR1 -> stay in RUN.
//    - Anything else -> FAIL, fail_code=1. This includes PASS_ADDR carrying wrong data.
//  - Timeout: cycle counter increments each RUN cycle and clears on any store.
//    - Counter reaching TIMEOUT-1 with memwrite=0 -> FAIL, fail_code=2.
//    - A store in that same cycle wins: it is evaluated and the counter clears.
//  - Verdict outputs assert the cycle after the deciding edge; done=pass|fail. fail_code is held.
//  - Stores in PASS/FAIL are ignored: not counted, not logged.
//  - Every RUN store, including the deciding one, increments store_count and is pushed into the trace FIFO.
//  - Trace FIFO is circular, with trace_count in 0..DEPTH.
//    - Push when full, no pop: oldest entry dropped, newest written, count stays DEPTH, overflow<=1.
//    - Push and pop in the same cycle when full: pop returns the oldest; no drop, no overflow.
//    - Pop when empty: ignored; rd_valid stays 0.
//    - Push into empty with rd_req the same cycle: pop ignored; the entry is stored.
//  - Readout: rd_req=1 when trace_count>0 -> next cycle rd_valid=1, with rd_addr/rd_data = oldest entry.
//    rd_addr/rd_data hold their last value when rd_valid=0. Readout works in every state.
//    Back-to-back rd_req gives one entry per cycle.
//  - Pointer wrap is modulo DEPTH; count and pointers never exceed range.
// TESTING
//  - Stores (80,x),(0x1107,y),(84,0x1118) -> pass=1 one cycle after 3rd store; fail=0; store_count=3; trace_count=3.
//  - Store (84,0x1117) -> fail=1, fail_code=1, pass=0; a later (84,0x1118) leaves pass=0 and store_count=1.
//  - TIMEOUT=16, no stores -> fail=1, fail_code=2 on the 17th cycle after reset release.
//    Store (80,x) at cycle 15 -> no fail that cycle.
//  - DEPTH=8, 10 stores to 80 with data 0..9 -> overflow=1, trace_count=8.
//    Draining with 8 rd_req yields data 2..9 in order, then rd_valid=0 on a 9th req.
//  - Full FIFO, simultaneous store and rd_req -> pop returns the oldest, count stays 8, overflow unchanged.
//  - Reset asserted for 1 cycle after PASS with 5 entries logged -> all outputs 0, trace_count=0, FSM back in RUN.

Source files
------------

// File: rtl/store_monitor_if.sv
// Store-port and trace-readout signals shared by the CPU top and the store monitor.
// The master side drives stores and pop requests; the monitor is the slave.
interface store_monitor_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;

  modport master (
    output memwrite, dataadr, writedata, rd_req,
    input  rd_valid, rd_addr, rd_data
  );

  modport slave (
    input  memwrite, dataadr, writedata, rd_req,
    output rd_valid, rd_addr, rd_data
  );
endinterface

// File: rtl/store_monitor.sv
// Self-check unit on the data-memory write port: pass/fail verdict, timeout detection,
// and a circular trace FIFO of recent stores drained through a request/valid readout.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR   = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'h00001118,
  parameter logic [31:0] ALLOW_ADDR0 = 32'd80,
  parameter logic [31:0] ALLOW_ADDR1 = 32'h00001107,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  store_monitor_if.slave             bus,
  output logic [$clog2(DEPTH):0]     trace_count,
  output logic                       overflow,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [15:0]                store_count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StPass, StFail} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [1:0]      fail_code_q, fail_code_d;

  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            rd_valid_q;
  logic [31:0]     rd_addr_q, rd_data_q;
  logic [15:0]     store_count_q;
  logic [31:0]     mem_addr [DEPTH];
  logic [31:0]     mem_data [DEPTH];

  logic            push, pop, full;

  assign push = (state_q == StRun) && bus.memwrite;
  assign pop  = bus.rd_req && (count_q != '0);
  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fail_code_d = fail_code_q;
    if (state_q == StRun) begin
      if (bus.memwrite) begin
        // A store always beats a timeout landing in the same cycle.
        cnt_d = '0;
        if (bus.dataadr == PASS_ADDR && bus.writedata == PASS_DATA) begin
          state_d = StPass;
        end else if (!(bus.dataadr == ALLOW_ADDR0 || bus.dataadr == ALLOW_ADDR1)) begin
          state_d     = StFail;
          fail_code_d = 2'd1;
        end
      end else if (cnt_q == TW'(TIMEOUT - 1)) begin
        state_d     = StFail;
        fail_code_d = 2'd2;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      fail_code_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      store_count_q <= '0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_addr_q <= mem_addr[rd_ptr_q];
        rd_data_q <= mem_data[rd_ptr_q];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      // Full push without pop overwrites the oldest, so the read side must skip it.
      if (pop || (push && full)) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop && !full) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (push && store_count_q != 16'hFFFF) begin
        store_count_q <= store_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_addr[wr_ptr_q] <= bus.dataadr;
      mem_data[wr_ptr_q] <= bus.writedata;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign trace_count  = count_q;
  assign overflow     = overflow_q;
  assign pass         = (state_q == StPass);
  assign fail         = (state_q == StFail);
  assign done         = pass | fail;
  assign fail_code    = fail_code_q;
  assign store_count  = store_count_q;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: a vector table for the verdict/readout flows, plus
// hand-written sequences for timeout and FIFO overflow corners.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  trace_count;
  logic        overflow, done, pass, fail;
  logic [1:0]  fail_code;
  logic [15:0] store_count;

  int tests  = 0;
  int errors = 0;

  store_monitor_if bus ();

  store_monitor #(
    .DEPTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .trace_count (trace_count),
    .overflow    (overflow),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        req;
    logic        e_done;
    logic        e_pass;
    logic        e_fail;
    logic [1:0]  e_code;
    logic [15:0] e_scnt;
    logic [3:0]  e_tcnt;
    logic        e_ovf;
    logic        e_rv;
    logic [31:0] e_ra;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic rst, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic req);
    reset         = rst;
    bus.memwrite  = we;
    bus.dataadr   = adr;
    bus.writedata = dat;
    bus.rd_req    = req;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.memwrite = 1'b0;
    bus.rd_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.rd_req    = 1'b0;

    //              rst we adr        dat        req dn ps fl cd scnt tc ov rv ra         rd
    vecs.push_back('{1, 0, 32'd0,     32'd0,     0,  0, 0, 0, 0, 0,   0, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd80,    32'hAA,    0,  0, 0, 0, 0, 1,   1, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'h1107,  32'hBB,    0,  0, 0, 0, 0, 2,   2, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd84,    32'h1118,  0,  1, 1, 0, 0, 3,   3, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd80,    32'hCC,    1,  1, 1, 0, 0, 3,   2, 0, 1, 32'd80,    32'hAA});
    vecs.push_back('{0, 0, 32'd0,     32'd0,     1,  1, 1, 0, 0, 3,   1, 0, 1, 32'h1107,  32'hBB});
    vecs.push_back('{0, 0, 32'd0,     32'd0,     1,  1, 1, 0, 0, 3,   0, 0, 1, 32'd84,    32'h1118});
    vecs.push_back('{0, 0, 32'd0,     32'd0,     1,  1, 1, 0, 0, 3,   0, 0, 0, 32'd84,    32'h1118});
    vecs.push_back('{1, 0, 32'd0,     32'd0,     0,  0, 0, 0, 0, 0,   0, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd84,    32'h1117,  0,  1, 0, 1, 1, 1,   1, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd84,    32'h1118,  0,  1, 0, 1, 1, 1,   1, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 0, 32'd0,     32'd0,     1,  1, 0, 1, 1, 1,   0, 0, 1, 32'd84,    32'h1117});
    vecs.push_back('{1, 0, 32'd0,     32'd0,     0,  0, 0, 0, 0, 0,   0, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd80,    32'd1,     0,  0, 0, 0, 0, 1,   1, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd80,    32'd2,     0,  0, 0, 0, 0, 2,   2, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'h1107,  32'd3,     0,  0, 0, 0, 0, 3,   3, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd80,    32'd4,     0,  0, 0, 0, 0, 4,   4, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd84,    32'h1118,  0,  1, 1, 0, 0, 5,   5, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 1, 32'd80,    32'd4,     1,  1, 1, 0, 0, 5,   4, 0, 1, 32'd80,    32'd1});
    vecs.push_back('{1, 0, 32'd0,     32'd0,     0,  0, 0, 0, 0, 0,   0, 0, 0, 32'd0,     32'd0});
    // Back in RUN: push into empty with a same-cycle pop request; the pop is ignored.
    vecs.push_back('{0, 1, 32'd80,    32'd5,     1,  0, 0, 0, 0, 1,   1, 0, 0, 32'd0,     32'd0});
    vecs.push_back('{0, 0, 32'd0,     32'd0,     1,  0, 0, 0, 0, 1,   0, 0, 1, 32'd80,    32'd5});
    vecs.push_back('{1, 0, 32'd0,     32'd0,     0,  0, 0, 0, 0, 0,   0, 0, 0, 32'd0,     32'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].req);
      chk($sformatf("v%0d done", i),  32'(done),         32'(vecs[i].e_done));
      chk($sformatf("v%0d pass", i),  32'(pass),         32'(vecs[i].e_pass));
      chk($sformatf("v%0d fail", i),  32'(fail),         32'(vecs[i].e_fail));
      chk($sformatf("v%0d code", i),  32'(fail_code),    32'(vecs[i].e_code));
      chk($sformatf("v%0d scnt", i),  32'(store_count),  32'(vecs[i].e_scnt));
      chk($sformatf("v%0d tcnt", i),  32'(trace_count),  32'(vecs[i].e_tcnt));
      chk($sformatf("v%0d ovf", i),   32'(overflow),     32'(vecs[i].e_ovf));
      chk($sformatf("v%0d rv", i),    32'(bus.rd_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d raddr", i), bus.rd_addr,       vecs[i].e_ra);
      chk($sformatf("v%0d rdata", i), bus.rd_data,       vecs[i].e_rd);
    end

    // Timeout with no stores: fail visible after the 16th post-reset edge.
    for (int c = 1; c <= 16; c++) begin
      idle(1);
      chk($sformatf("to c%0d fail", c), 32'(fail), (c == 16) ? 32'd1 : 32'd0);
    end
    chk("to code", 32'(fail_code), 32'd2);
    chk("to done", 32'(done), 32'd1);

    // A store in the timeout cycle wins and restarts the count.
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(15);
    chk("to pre fail", 32'(fail), 32'd0);
    cyc(1'b0, 1'b1, 32'd80, 32'h55, 1'b0);
    chk("to store fail", 32'(fail), 32'd0);
    idle(15);
    chk("to late fail", 32'(fail), 32'd0);
    idle(1);
    chk("to late fail2", 32'(fail), 32'd1);
    chk("to late code", 32'(fail_code), 32'd2);

    // Overflow: ten stores into an 8-deep buffer drop data 0 and 1.
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 32'd80, 32'(i), 1'b0);
      chk($sformatf("ovf s%0d tcnt", i), 32'(trace_count), (i < 8) ? 32'(i + 1) : 32'd8);
      chk($sformatf("ovf s%0d ovf", i), 32'(overflow), (i >= 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      chk($sformatf("drain %0d rv", i), 32'(bus.rd_valid), (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) chk($sformatf("drain %0d data", i), bus.rd_data, 32'(i + 2));
    end
    chk("drain tcnt", 32'(trace_count), 32'd0);
    chk("drain ovf sticky", 32'(overflow), 32'd1);

    // Full buffer with simultaneous push and pop: no drop, no overflow.
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'd80, 32'(i + 16), 1'b0);
    chk("full tcnt", 32'(trace_count), 32'd8);
    cyc(1'b0, 1'b1, 32'd80, 32'd24, 1'b1);
    chk("pp rv", 32'(bus.rd_valid), 32'd1);
    chk("pp data", bus.rd_data, 32'd16);
    chk("pp tcnt", 32'(trace_count), 32'd8);
    chk("pp ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("pp next data", bus.rd_data, 32'd17);
    chk("pp next tcnt", 32'(trace_count), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
